// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared types and AXI response codes for the AXI4-Lite command master
package axil_pkg;

  // Transaction sequencer states
  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_B,
    RD_AR,
    RD_R,
    RSP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // One fabric command as it is about to be issued (address already masked)
  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } cmd_t;

endpackage

// File: rtl/axil_cmd_master_if.sv
// rtl/axil_cmd_master_if.sv - AXI4-Lite bus bundle with master/slave views
interface axil_cmd_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axil_cmd_stats.sv
// rtl/axil_cmd_stats.sv - saturating write/read/error counters (used when AXIL_CMD_MASTER_STATS_EN is defined)
module axil_cmd_stats
  import axil_pkg::*;
(
  input  logic        aclk,
  input  logic        arst,
  input  logic        stat_clr,
  input  logic        b_fire,
  input  logic        r_fire,
  input  logic [1:0]  bresp,
  input  logic [1:0]  rresp,
  output logic [31:0] stat_wr_cnt,
  output logic [31:0] stat_rd_cnt,
  output logic [15:0] stat_err_cnt
);
  logic err_hit;

  assign err_hit = (b_fire && bresp != RESP_OKAY) || (r_fire && rresp != RESP_OKAY);

  // Count completed B/R handshakes and non-OKAY responses; clear wins over increment
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      stat_wr_cnt  <= '0;
      stat_rd_cnt  <= '0;
      stat_err_cnt <= '0;
    end else if (stat_clr) begin
      stat_wr_cnt  <= '0;
      stat_rd_cnt  <= '0;
      stat_err_cnt <= '0;
    end else begin
      if (b_fire && stat_wr_cnt != '1) stat_wr_cnt <= stat_wr_cnt + 32'd1;
      if (r_fire && stat_rd_cnt != '1) stat_rd_cnt <= stat_rd_cnt + 32'd1;
      if (err_hit && stat_err_cnt != '1) stat_err_cnt <= stat_err_cnt + 16'd1;
    end
  end
endmodule

// File: rtl/axil_cmd_master.sv
// rtl/axil_cmd_master.sv - single-outstanding AXI4-Lite initiator driven by a cmd/rsp port; AXIL_CMD_MASTER_STATS_EN adds counters
module axil_cmd_master
  import axil_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] ADDR_MASK  = 'hC
) (
  input  logic                    aclk,
  input  logic                    arst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_data,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic [1:0]              rsp_resp,
`ifdef AXIL_CMD_MASTER_STATS_EN
  input  logic                    stat_clr,
  output logic [31:0]             stat_wr_cnt,
  output logic [31:0]             stat_rd_cnt,
  output logic [15:0]             stat_err_cnt,
`endif
  axil_cmd_master_if.master       m_axil
);
  localparam int STRB_W = DATA_WIDTH / 8;
  // Word-aligned issue: the two byte-lane bits never reach the bus
  localparam logic [ADDR_WIDTH-1:0] ISSUE_MASK = ADDR_MASK & ~ADDR_WIDTH'(3);

  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("axil_cmd_master: only DATA_WIDTH=32 is supported");
  end

  state_t                state;
  cmd_t                  cmd_in;
  logic                  aw_done, w_done;
  logic [ADDR_WIDTH-1:0] awaddr_q, araddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic                  awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic                  aw_fire, w_fire, b_fire, ar_fire, r_fire;

  assign cmd_in = '{write: cmd_write,
                    addr:  32'(cmd_addr & ISSUE_MASK),
                    data:  32'(cmd_data),
                    strb:  4'(cmd_strb)};

  assign aw_fire = awvalid_q & m_axil.awready;
  assign w_fire  = wvalid_q  & m_axil.wready;
  assign b_fire  = bready_q  & m_axil.bvalid;
  assign ar_fire = arvalid_q & m_axil.arready;
  assign r_fire  = rready_q  & m_axil.rvalid;

  assign m_axil.awaddr  = awaddr_q;
  assign m_axil.awprot  = 3'b000;
  assign m_axil.awvalid = awvalid_q;
  assign m_axil.wdata   = wdata_q;
  assign m_axil.wstrb   = wstrb_q;
  assign m_axil.wvalid  = wvalid_q;
  assign m_axil.bready  = bready_q;
  assign m_axil.araddr  = araddr_q;
  assign m_axil.arprot  = 3'b000;
  assign m_axil.arvalid = arvalid_q;
  assign m_axil.rready  = rready_q;

  // Transaction sequencer: accept, issue AW/W or AR, collect B or R, hold the response
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_data  <= '0;
      rsp_resp  <= '0;
      awaddr_q  <= '0;
      awvalid_q <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (cmd_in.write) begin
              awaddr_q  <= ADDR_WIDTH'(cmd_in.addr);
              wdata_q   <= DATA_WIDTH'(cmd_in.data);
              wstrb_q   <= STRB_W'(cmd_in.strb);
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done   <= 1'b0;
              w_done    <= 1'b0;
              state     <= WR;
            end else begin
              araddr_q  <= ADDR_WIDTH'(cmd_in.addr);
              arvalid_q <= 1'b1;
              state     <= RD_AR;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        WR: begin
          // AW and W retire independently; each valid falls only after its own handshake
          if (aw_fire) begin
            awvalid_q <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_fire) begin
            wvalid_q <= 1'b0;
            w_done   <= 1'b1;
          end
          if ((aw_done || aw_fire) && (w_done || w_fire)) begin
            bready_q <= 1'b1;
            state    <= WR_B;
          end
        end
        WR_B: begin
          if (b_fire) begin
            rsp_write <= 1'b1;
            rsp_data  <= '0;
            rsp_resp  <= m_axil.bresp;
            bready_q  <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RSP;
          end
        end
        RD_AR: begin
          if (ar_fire) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= RD_R;
          end
        end
        RD_R: begin
          if (r_fire) begin
            rsp_write <= 1'b0;
            rsp_data  <= m_axil.rdata;
            rsp_resp  <= m_axil.rresp;
            rready_q  <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AXIL_CMD_MASTER_STATS_EN
  axil_cmd_stats u_stats (
    .aclk         (aclk),
    .arst         (arst),
    .stat_clr     (stat_clr),
    .b_fire       (b_fire),
    .r_fire       (r_fire),
    .bresp        (m_axil.bresp),
    .rresp        (m_axil.rresp),
    .stat_wr_cnt  (stat_wr_cnt),
    .stat_rd_cnt  (stat_rd_cnt),
    .stat_err_cnt (stat_err_cnt)
  );
`endif
endmodule

// File: tb/tb_axil_cmd_master.sv
// tb/tb_axil_cmd_master.sv - directed vector bench for axil_cmd_master with a behavioural AXI4-Lite slave
module tb_axil_cmd_master;
  import axil_pkg::*;

  logic        aclk = 1'b0;
  logic        arst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic [3:0]  cmd_strb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_write;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_resp;
`ifdef AXIL_CMD_MASTER_STATS_EN
  logic        stat_clr = 1'b0;
  logic [31:0] stat_wr_cnt, stat_rd_cnt;
  logic [15:0] stat_err_cnt;
`endif

  always #5 aclk = ~aclk;

  axil_cmd_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m_axil ();

  axil_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ADDR_MASK(32'hC)) dut (
    .aclk      (aclk),
    .arst      (arst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .cmd_strb  (cmd_strb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_write (rsp_write),
    .rsp_data  (rsp_data),
    .rsp_resp  (rsp_resp),
`ifdef AXIL_CMD_MASTER_STATS_EN
    .stat_clr     (stat_clr),
    .stat_wr_cnt  (stat_wr_cnt),
    .stat_rd_cnt  (stat_rd_cnt),
    .stat_err_cnt (stat_err_cnt),
`endif
    .m_axil    (m_axil)
  );

  // Behavioural slave: ready after a programmable wait, registered B/R responses
  int          aw_delay = 0, w_delay = 0;
  int          aw_wait, w_wait;
  logic        b_hold = 1'b0;
  logic [1:0]  b_resp_cfg = 2'b00, rd_resp_cfg = 2'b00;
  logic [31:0] rd_data_cfg = '0;
  logic        aw_got, w_got;
  logic        s_bvalid, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata;
  logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
  logic [3:0]  cap_wstrb = '0;
  int          aw_count = 0, w_count = 0, b_count = 0, ar_count = 0, r_count = 0;
  logic        s_aw_fire, s_w_fire, s_ar_fire;

  assign m_axil.awready = m_axil.awvalid && (aw_wait >= aw_delay);
  assign m_axil.wready  = m_axil.wvalid && (w_wait >= w_delay);
  assign m_axil.arready = m_axil.arvalid;
  assign m_axil.bvalid  = s_bvalid;
  assign m_axil.bresp   = s_bresp;
  assign m_axil.rvalid  = s_rvalid;
  assign m_axil.rresp   = s_rresp;
  assign m_axil.rdata   = s_rdata;
  assign s_aw_fire = m_axil.awvalid && m_axil.awready;
  assign s_w_fire  = m_axil.wvalid && m_axil.wready;
  assign s_ar_fire = m_axil.arvalid && m_axil.arready;

  always @(posedge aclk or posedge arst) begin
    if (arst) begin
      aw_wait <= 0; w_wait <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      s_bvalid <= 1'b0; s_bresp <= 2'b00; s_rvalid <= 1'b0; s_rresp <= 2'b00; s_rdata <= '0;
    end else begin
      aw_wait <= (m_axil.awvalid && !m_axil.awready) ? aw_wait + 1 : 0;
      w_wait  <= (m_axil.wvalid && !m_axil.wready) ? w_wait + 1 : 0;
      if (s_aw_fire) begin aw_got <= 1'b1; cap_awaddr <= m_axil.awaddr; aw_count <= aw_count + 1; end
      if (s_w_fire) begin
        w_got <= 1'b1; cap_wdata <= m_axil.wdata; cap_wstrb <= m_axil.wstrb; w_count <= w_count + 1;
      end
      if ((aw_got || s_aw_fire) && (w_got || s_w_fire) && !b_hold) begin
        s_bvalid <= 1'b1; s_bresp <= b_resp_cfg; aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (s_bvalid && m_axil.bready) begin s_bvalid <= 1'b0; b_count <= b_count + 1; end
      if (s_ar_fire) begin
        cap_araddr <= m_axil.araddr; ar_count <= ar_count + 1;
        s_rvalid <= 1'b1; s_rdata <= rd_data_cfg; s_rresp <= rd_resp_cfg;
      end
      if (s_rvalid && m_axil.rready) begin s_rvalid <= 1'b0; r_count <= r_count + 1; end
    end
  end

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic [31:0] exp_addr;
    logic [31:0] exp_rsp_data;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one command and wait for its acceptance edge; leaves time at 1 ns after that edge
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input string tag);
    int n = 0;
    cmd_write = wr; cmd_addr = addr; cmd_data = data; cmd_strb = strb; cmd_valid = 1'b1;
    while (!cmd_ready && n < 20) begin @(posedge aclk); #1; n++; end
    check({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
    @(posedge aclk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 50) begin @(posedge aclk); #1; lat++; end
  endtask

  task automatic consume(input string tag);
    rsp_ready = 1'b1;
    @(posedge aclk); #1;
    rsp_ready = 1'b0;
    check({tag, " rsp_valid drop"}, 32'(rsp_valid), 32'd0);
    check({tag, " cmd_ready back"}, 32'(cmd_ready), 32'd1);
  endtask

  // Handshake cycle, issue cycle, response-wait cycle, then rsp_valid: two edges after acceptance
  localparam int LAT_EDGES = 2;

  task automatic apply_vec(input vec_t v, input string tag);
    int lat;
    b_resp_cfg = v.resp; rd_resp_cfg = v.resp; rd_data_cfg = v.rdata;
    issue(v.write, v.addr, v.data, v.strb, tag);
    wait_rsp(lat);
    check({tag, " latency"}, 32'(lat), 32'(LAT_EDGES));
    if (v.write) begin
      check({tag, " awaddr"}, cap_awaddr, v.exp_addr);
      check({tag, " wdata"}, cap_wdata, v.data);
      check({tag, " wstrb"}, 32'(cap_wstrb), 32'(v.strb));
    end else begin
      check({tag, " araddr"}, cap_araddr, v.exp_addr);
    end
    check({tag, " rsp_write"}, 32'(rsp_write), 32'(v.write));
    check({tag, " rsp_data"}, rsp_data, v.exp_rsp_data);
    check({tag, " rsp_resp"}, 32'(rsp_resp), 32'(v.resp));
    consume(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    int   lat, n, bad, aw0, b0, ar0;

    //          wr  addr           data           strb   rdata          resp   exp_addr  exp_rsp_data
    vecs[0] = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 32'h0,         2'b00, 32'h8, 32'h0};
    vecs[1] = '{1'b0, 32'h0000_0007, 32'h0,         4'h0, 32'h1234_5678, 2'b00, 32'h4, 32'h1234_5678};
    vecs[2] = '{1'b1, 32'h0000_00FF, 32'hA5A5_5A5A, 4'h3, 32'h0,         2'b10, 32'hC, 32'h0};
    vecs[3] = '{1'b0, 32'h0000_0003, 32'h0,         4'h0, 32'hCAFE_F00D, 2'b10, 32'h0, 32'hCAFE_F00D};
    vecs[4] = '{1'b0, 32'h0001_0008, 32'h0,         4'h0, 32'h0,         2'b11, 32'h8, 32'h0};
    vecs[5] = '{1'b1, 32'h0000_0004, 32'h0,         4'h0, 32'h0,         2'b01, 32'h4, 32'h0};

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    check("reset cmd_ready", 32'(cmd_ready), 32'd0);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset bus valids/readies",
          32'({m_axil.awvalid, m_axil.wvalid, m_axil.bready, m_axil.arvalid, m_axil.rready}), 32'd0);
    check("reset awaddr", m_axil.awaddr, 32'h0);
    check("reset araddr", m_axil.araddr, 32'h0);
    check("reset rsp fields", 32'({rsp_write, rsp_resp}) | rsp_data, 32'd0);
    arst = 1'b0;
    @(posedge aclk); #1;
    check("cmd_ready after reset", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 6; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

`ifdef AXIL_CMD_MASTER_STATS_EN
    check("stats wr after table", stat_wr_cnt, 32'd3);
    check("stats rd after table", stat_rd_cnt, 32'd3);
    check("stats err after table", 32'(stat_err_cnt), 32'd4);
    stat_clr = 1'b1;
    @(posedge aclk); #1;
    stat_clr = 1'b0;
    check("stats cleared", stat_wr_cnt | stat_rd_cnt | 32'(stat_err_cnt), 32'd0);
`endif

    // AW accepted immediately, W three cycles later
    aw_delay = 0; w_delay = 3; b_resp_cfg = 2'b00;
    aw0 = aw_count; b0 = b_count;
    issue(1'b1, 32'h8, 32'h1122_3344, 4'hF, "split");
    check("split both valid", 32'({m_axil.awvalid, m_axil.wvalid}), 32'b11);
    @(posedge aclk); #1;
    check("split aw dropped w held", 32'({m_axil.awvalid, m_axil.wvalid}), 32'b01);
    n = 0; bad = 0;
    while (!(m_axil.wvalid && m_axil.wready) && n < 20) begin
      @(posedge aclk); #1; n++;
      if (m_axil.awvalid || !m_axil.wvalid) bad++;
    end
    check("split w wait cycles", 32'(n), 32'd2);
    check("split valids during wait", 32'(bad), 32'd0);
    wait_rsp(lat);
    check("split rsp seen", 32'(rsp_valid), 32'd1);
    check("split wdata", cap_wdata, 32'h1122_3344);
    check("split rsp_resp", 32'(rsp_resp), 32'd0);
    consume("split");
    repeat (2) @(posedge aclk);
    #1;
    check("split single AW", 32'(aw_count - aw0), 32'd1);
    check("split single B", 32'(b_count - b0), 32'd1);
    w_delay = 0;

    // SLVERR on a read passes straight through
    rd_resp_cfg = 2'b10; rd_data_cfg = 32'h0000_BAD0;
    issue(1'b0, 32'h0, 32'h0, 4'h0, "slverr");
    wait_rsp(lat);
    check("slverr rsp_resp", 32'(rsp_resp), 32'b10);
    check("slverr rsp_write", 32'(rsp_write), 32'd0);
    consume("slverr");
`ifdef AXIL_CMD_MASTER_STATS_EN
    check("stats err after slverr", 32'(stat_err_cnt), 32'd1);
    check("stats rd after slverr", stat_rd_cnt, 32'd1);
    check("stats wr after split", stat_wr_cnt, 32'd1);
`endif

    // Response held off for 10 cycles while a new command is waiting
    rd_resp_cfg = 2'b00; rd_data_cfg = 32'h5A5A_0001;
    issue(1'b0, 32'h8, 32'h0, 4'h0, "stall");
    wait_rsp(lat);
    cmd_write = 1'b1; cmd_addr = 32'h4; cmd_data = 32'hFFFF_FFFF; cmd_strb = 4'hF; cmd_valid = 1'b1;
    aw0 = aw_count; ar0 = ar_count; bad = 0;
    repeat (10) begin
      @(posedge aclk); #1;
      if (!rsp_valid || rsp_data !== 32'h5A5A_0001 || cmd_ready || m_axil.awvalid || m_axil.arvalid) bad++;
    end
    check("stall held stable", 32'(bad), 32'd0);
    check("stall no new AW/AR", 32'(aw_count - aw0) + 32'(ar_count - ar0), 32'd0);
    cmd_valid = 1'b0;
    consume("stall");

    // Reset asserted while waiting for B
    b_hold = 1'b1; b_resp_cfg = 2'b00; b0 = b_count;
    issue(1'b1, 32'h4, 32'h0BAD_F00D, 4'hF, "rst");
    n = 0;
    while (!m_axil.bready && n < 20) begin @(posedge aclk); #1; n++; end
    check("rst reached WR_B", 32'(m_axil.bready), 32'd1);
    #2 arst = 1'b1;
    #1;
    check("rst async valids/readies",
          32'({cmd_ready, rsp_valid, m_axil.awvalid, m_axil.wvalid, m_axil.bready, m_axil.arvalid, m_axil.rready}),
          32'd0);
    check("rst async awaddr", m_axil.awaddr, 32'h0);
    check("rst async wdata", m_axil.wdata, 32'h0);
    #1 arst = 1'b0;
    b_hold = 1'b0;
    bad = 0;
    repeat (3) begin
      @(posedge aclk); #1;
      if (rsp_valid) bad++;
    end
    check("rst no response", 32'(bad), 32'd0);
    check("rst no B accepted", 32'(b_count - b0), 32'd0);
    apply_vec('{1'b1, 32'h0000_000C, 32'h7777_8888, 4'hC, 32'h0, 2'b00, 32'hC, 32'h0}, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
